// File: rtl/usreg_nbits.sv
// ---------------------------------------------------------------------------
// usreg_nbits : N-bit universal shift register with a multi-cycle burst engine
//
// Single-cycle operations (en=1) apply one of eight modes to q. A burst
// (start=1 with a shift/rotate mode) repeats the selected shift amt times,
// one step per clock. During the burst busy is high. done pulses for one
// cycle when the burst completes.
//
// Ports
//   clk    in   1   rising-edge clock
//   reset  in   1   synchronous, active-high reset
//   en     in   1   single-cycle operation enable
//   mode   in   3   000 HOLD, 001 LOAD, 010 SHL, 011 SHR,
//                   100 ROL, 101 ROR, 110 ASR, 111 CLR
//   d      in   N   parallel load data
//   sin    in   1   serial input for SHL/SHR
//   start  in   1   burst request
//   amt    in   AW  burst step count, unsigned
//   q      out  N   register contents
//   sout   out  1   bit most recently shifted out of q
//   busy   out  1   burst in progress
//   done   out  1   one-cycle burst-complete pulse
// ---------------------------------------------------------------------------
module usreg_nbits #(
   parameter int N  = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic [2:0]    mode,
   input  logic [N-1:0]  d,
   input  logic          sin,
   input  logic          start,
   input  logic [AW-1:0] amt,
   output logic [N-1:0]  q,
   output logic          sout,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] M_HOLD = 3'b000;
   localparam logic [2:0] M_LOAD = 3'b001;
   localparam logic [2:0] M_SHL  = 3'b010;
   localparam logic [2:0] M_SHR  = 3'b011;
   localparam logic [2:0] M_ROL  = 3'b100;
   localparam logic [2:0] M_ROR  = 3'b101;
   localparam logic [2:0] M_ASR  = 3'b110;
   localparam logic [2:0] M_CLR  = 3'b111;

   state_t        state;
   logic [2:0]    lmode;
   logic [AW-1:0] cnt;

   // One shift/rotate step. The result packs the bit leaving the register
   // in the MSB position and the new register value below it, so the
   // caller can update q and sout together.
   function automatic logic [N:0] shift_op(input logic [2:0]   op,
                                           input logic [N-1:0] cur,
                                           input logic         si);
      case (op)
         M_SHL:   shift_op = {cur[N-1], cur[N-2:0], si};
         M_SHR:   shift_op = {cur[0], si, cur[N-1:1]};
         M_ROL:   shift_op = {cur[N-1], cur[N-2:0], cur[N-1]};
         M_ROR:   shift_op = {cur[0], cur[0], cur[N-1:1]};
         M_ASR:   shift_op = {cur[0], cur[N-1], cur[N-1:1]};
         default: shift_op = {1'b0, cur};
      endcase
   endfunction

   // Only the five shift/rotate encodings can launch a burst; HOLD, LOAD
   // and CLR with start=1 fall through to the ordinary en path.
   logic       start_ok;
   logic [N:0] live_step;
   logic [N:0] burst_step;

   // Precompute the step results for the live mode and for the latched
   // burst mode so the state machine below stays readable.
   always_comb begin
      start_ok   = start && (mode >= M_SHL) && (mode <= M_ASR);
      live_step  = shift_op(mode, q, sin);
      burst_step = shift_op(lmode, q, sin);
   end

   // Main state machine. Reset wins over everything; BUSY and DONE ignore
   // all control inputs; in IDLE a valid start takes priority over en.
   // busy and done are registered alongside the state so they track it
   // exactly.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         lmode <= M_HOLD;
         cnt   <= '0;
         q     <= '0;
         sout  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_ok) begin
                  lmode <= mode;
                  if (amt == '0) begin
                     cnt   <= '0;
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     // The first step happens on the start edge itself,
                     // so only amt-1 steps remain for the BUSY state.
                     q    <= live_step[N-1:0];
                     sout <= live_step[N];
                     cnt  <= amt - AW'(1);
                     if (amt == AW'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end else begin
                        state <= BUSY;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                     end
                  end
               end else if (en) begin
                  case (mode)
                     M_HOLD: q <= q;
                     M_LOAD: q <= d;
                     M_CLR:  q <= '0;
                     default: begin
                        q    <= live_step[N-1:0];
                        sout <= live_step[N];
                     end
                  endcase
                  busy <= 1'b0;
                  done <= 1'b0;
               end else begin
                  busy <= 1'b0;
                  done <= 1'b0;
               end
            end

            BUSY: begin
               q    <= burst_step[N-1:0];
               sout <= burst_step[N];
               cnt  <= cnt - AW'(1);
               if (cnt == AW'(1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  busy <= 1'b1;
                  done <= 1'b0;
               end
            end

            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_usreg_nbits.sv
// ---------------------------------------------------------------------------
// tb_usreg_nbits : directed self-checking bench for usreg_nbits (N=8, AW=4)
//
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at that same point, so every check sees the result of the edge
// just taken. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_usreg_nbits;

   localparam int N  = 8;
   localparam int AW = 4;

   logic          clk;
   logic          reset;
   logic          en;
   logic [2:0]    mode;
   logic [N-1:0]  d;
   logic          sin;
   logic          start;
   logic [AW-1:0] amt;
   logic [N-1:0]  q;
   logic          sout;
   logic          busy;
   logic          done;

   int total;
   int bad;

   usreg_nbits #(.N(N), .AW(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .mode  (mode),
      .d     (d),
      .sin   (sin),
      .start (start),
      .amt   (amt),
      .q     (q),
      .sout  (sout),
      .busy  (busy),
      .done  (done)
   );

   // 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value and count it.
   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a full set of control inputs for the next edge.
   task automatic applyStimulus(input logic e, input logic [2:0] m,
                                input logic [N-1:0] dv, input logic s,
                                input logic st, input logic [AW-1:0] a);
      en    = e;
      mode  = m;
      d     = dv;
      sin   = s;
      start = st;
      amt   = a;
   endtask

   // Parallel-load a value in a single cycle.
   task automatic loadValue(input logic [N-1:0] v);
      applyStimulus(1'b1, 3'b001, v, 1'b0, 1'b0, '0);
      tick();
      applyStimulus(1'b0, 3'b000, '0, 1'b0, 1'b0, '0);
   endtask

   int cycles;
   int doneSeen;
   int busySeen;

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      applyStimulus(1'b0, 3'b000, '0, 1'b0, 1'b0, '0);

      // Reset for two cycles
      tick();
      tick();
      checkOutput("rst_q",    32'(q),    32'h00);
      checkOutput("rst_sout", 32'(sout), 32'h0);
      checkOutput("rst_busy", 32'(busy), 32'h0);
      checkOutput("rst_done", 32'(done), 32'h0);

      // First edge out of reset accepts a LOAD
      reset = 1'b0;
      applyStimulus(1'b1, 3'b001, 8'hA5, 1'b0, 1'b0, '0);
      tick();
      checkOutput("load_q",    32'(q),    32'hA5);
      checkOutput("load_busy", 32'(busy), 32'h0);
      checkOutput("load_done", 32'(done), 32'h0);

      // Single-cycle ops chained from A5
      applyStimulus(1'b1, 3'b010, '0, 1'b1, 1'b0, '0);        // SHL sin=1
      tick();
      checkOutput("shl_q",    32'(q),    32'h4B);
      checkOutput("shl_sout", 32'(sout), 32'h1);
      applyStimulus(1'b1, 3'b011, '0, 1'b0, 1'b0, '0);        // SHR sin=0
      tick();
      checkOutput("shr_q",    32'(q),    32'h25);
      checkOutput("shr_sout", 32'(sout), 32'h1);
      applyStimulus(1'b1, 3'b101, '0, 1'b0, 1'b0, '0);        // ROR
      tick();
      checkOutput("ror_q",    32'(q),    32'h92);
      checkOutput("ror_sout", 32'(sout), 32'h1);
      applyStimulus(1'b1, 3'b110, '0, 1'b0, 1'b0, '0);        // ASR
      tick();
      checkOutput("asr_q",    32'(q),    32'hC9);
      checkOutput("asr_sout", 32'(sout), 32'h0);
      applyStimulus(1'b1, 3'b100, '0, 1'b0, 1'b0, '0);        // ROL
      tick();
      checkOutput("rol_q",    32'(q),    32'h93);
      checkOutput("rol_sout", 32'(sout), 32'h1);
      applyStimulus(1'b1, 3'b000, 8'h11, 1'b0, 1'b0, '0);     // HOLD
      tick();
      checkOutput("hold_q",    32'(q),    32'h93);
      checkOutput("hold_sout", 32'(sout), 32'h1);
      applyStimulus(1'b0, 3'b001, 8'h00, 1'b0, 1'b0, '0);     // en=0
      tick();
      checkOutput("en0_q", 32'(q), 32'h93);
      applyStimulus(1'b1, 3'b111, '0, 1'b0, 1'b0, '0);        // CLR
      tick();
      checkOutput("clr_q",    32'(q),    32'h00);
      checkOutput("clr_sout", 32'(sout), 32'h1);
      applyStimulus(1'b1, 3'b001, 8'h5A, 1'b0, 1'b1, 4'd3);   // start ignored
      tick();
      checkOutput("ignst_q",    32'(q),    32'h5A);
      checkOutput("ignst_busy", 32'(busy), 32'h0);
      checkOutput("ignst_done", 32'(done), 32'h0);

      // ROL burst of 3 from 81
      loadValue(8'h81);
      applyStimulus(1'b0, 3'b100, '0, 1'b0, 1'b1, 4'd3);
      tick();
      applyStimulus(1'b0, 3'b000, '0, 1'b0, 1'b0, '0);
      checkOutput("rol3_q1",    32'(q),    32'h03);
      checkOutput("rol3_busy1", 32'(busy), 32'h1);
      tick();
      checkOutput("rol3_q2",    32'(q),    32'h06);
      checkOutput("rol3_busy2", 32'(busy), 32'h1);
      tick();
      checkOutput("rol3_q",    32'(q),    32'h0C);
      checkOutput("rol3_sout", 32'(sout), 32'h0);
      checkOutput("rol3_busy", 32'(busy), 32'h0);
      checkOutput("rol3_done", 32'(done), 32'h1);
      tick();
      checkOutput("rol3_done_off", 32'(done), 32'h0);

      // ASR burst of 9 from 80, latency counted with a bounded wait
      loadValue(8'h80);
      applyStimulus(1'b0, 3'b110, '0, 1'b0, 1'b1, 4'd9);
      tick();
      applyStimulus(1'b0, 3'b000, '0, 1'b0, 1'b0, '0);
      cycles = 1;
      while (!done && cycles < 20) begin
         tick();
         cycles++;
      end
      checkOutput("asr9_latency", 32'(cycles), 32'd9);
      checkOutput("asr9_q",       32'(q),      32'hFF);
      checkOutput("asr9_sout",    32'(sout),   32'h1);
      tick();

      // amt=0: no shift, done next cycle, busy never high
      loadValue(8'h3C);
      applyStimulus(1'b0, 3'b010, '0, 1'b1, 1'b1, 4'd0);
      tick();
      applyStimulus(1'b0, 3'b000, '0, 1'b0, 1'b0, '0);
      checkOutput("amt0_done", 32'(done), 32'h1);
      checkOutput("amt0_busy", 32'(busy), 32'h0);
      checkOutput("amt0_q",    32'(q),    32'h3C);
      tick();
      checkOutput("amt0_done_off", 32'(done), 32'h0);
      checkOutput("amt0_q2",       32'(q),    32'h3C);

      // Reset in the middle of an SHR burst of 6
      loadValue(8'hB4);
      applyStimulus(1'b0, 3'b011, '0, 1'b0, 1'b1, 4'd6);
      tick();
      applyStimulus(1'b0, 3'b000, '0, 1'b0, 1'b0, '0);
      tick();
      checkOutput("abort_q_pre",    32'(q),    32'h2D);
      checkOutput("abort_busy_pre", 32'(busy), 32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("abort_q",    32'(q),    32'h00);
      checkOutput("abort_busy", 32'(busy), 32'h0);
      doneSeen = 0;
      busySeen = 0;
      for (int i = 0; i < 8; i++) begin
         if (done) doneSeen++;
         if (busy) busySeen++;
         tick();
      end
      checkOutput("abort_no_done", 32'(doneSeen), 32'd0);
      checkOutput("abort_no_busy", 32'(busySeen), 32'd0);

      // SHL burst of 4 from 01 with noisy inputs during BUSY
      loadValue(8'h01);
      applyStimulus(1'b0, 3'b010, '0, 1'b1, 1'b1, 4'd4);
      tick();
      checkOutput("noisy_q1", 32'(q), 32'h03);
      applyStimulus(1'b1, 3'b001, 8'hFF, 1'b0, 1'b0, 4'd2);
      tick();
      checkOutput("noisy_q2", 32'(q), 32'h06);
      applyStimulus(1'b0, 3'b111, 8'hFF, 1'b1, 1'b1, 4'd1);
      tick();
      checkOutput("noisy_q3", 32'(q), 32'h0D);
      applyStimulus(1'b1, 3'b111, 8'hFF, 1'b1, 1'b0, 4'd7);
      tick();
      checkOutput("noisy_q",    32'(q),    32'h1B);
      checkOutput("noisy_sout", 32'(sout), 32'h0);
      checkOutput("noisy_done", 32'(done), 32'h1);
      // start arriving while in DONE must be ignored
      applyStimulus(1'b0, 3'b011, '0, 1'b0, 1'b1, 4'd2);
      tick();
      applyStimulus(1'b0, 3'b000, '0, 1'b0, 1'b0, '0);
      checkOutput("dnst_q",    32'(q),    32'h1B);
      checkOutput("dnst_busy", 32'(busy), 32'h0);
      checkOutput("dnst_done", 32'(done), 32'h0);

      // amt=1 ROR goes straight to DONE
      applyStimulus(1'b0, 3'b101, '0, 1'b0, 1'b1, 4'd1);
      tick();
      applyStimulus(1'b0, 3'b000, '0, 1'b0, 1'b0, '0);
      checkOutput("amt1_q",    32'(q),    32'h8D);
      checkOutput("amt1_sout", 32'(sout), 32'h1);
      checkOutput("amt1_busy", 32'(busy), 32'h0);
      checkOutput("amt1_done", 32'(done), 32'h1);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
